// File: rtl/instruction_fetch_scheduler_if.sv
// instruction_fetch_scheduler_if: flush, memory-port and instruction-buffer signals of the fetch scheduler
interface instruction_fetch_scheduler_if;
  logic        iSTART;
  logic        iFLUSH;
  logic [31:0] iFLUSH_PC;
  logic [4:0]  iBUF_COUNT;
  logic        oREQ_VALID;
  logic [31:0] oREQ_ADDR;
  logic        iREQ_BUSY;
  logic        iRSP_VALID;
  logic [31:0] iRSP_INST;
  logic [11:0] iRSP_MMU_FLAGS;
  logic        oINST_VALID;
  logic [31:0] oINST;
  logic [31:0] oPC;
  logic [11:0] oMMU_FLAGS;
  logic        oPROTO_ERR;
  modport master (
    input  iSTART, iFLUSH, iFLUSH_PC, iBUF_COUNT, iREQ_BUSY, iRSP_VALID, iRSP_INST, iRSP_MMU_FLAGS,
    output oREQ_VALID, oREQ_ADDR, oINST_VALID, oINST, oPC, oMMU_FLAGS, oPROTO_ERR
  );
  modport slave (
    output iSTART, iFLUSH, iFLUSH_PC, iBUF_COUNT, iREQ_BUSY, iRSP_VALID, iRSP_INST, iRSP_MMU_FLAGS,
    input  oREQ_VALID, oREQ_ADDR, oINST_VALID, oINST, oPC, oMMU_FLAGS, oPROTO_ERR
  );
endinterface

// File: rtl/instruction_fetch_scheduler.sv
// instruction_fetch_scheduler: credit-throttled fetch issue with flush redirect and stale-response discard
module instruction_fetch_scheduler #(
  parameter int          P_MAX_OUTSTANDING = 4,
  parameter int          P_CNT_W           = 3,
  parameter logic [5:0]  P_STOP_LEVEL      = 6'd26,
  parameter logic [31:0] P_RESET_PC        = 32'h0
) (
  input logic iCLOCK,
  input logic inRESET,
  instruction_fetch_scheduler_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t               state_q, state_d;
  logic [31:0]          pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [P_CNT_W-1:0]   out_q, out_d, disc_q, disc_d;
  logic                 inst_valid_q, inst_valid_d, proto_err_q, proto_err_d;
  logic [31:0]          inst_q, inst_d, opc_q, opc_d;
  logic [11:0]          flags_q, flags_d;
  logic [5:0]           credit;
  logic                 req_valid, accept, rsp_ok, keep;
  always_comb begin
    credit    = 6'(bus.iBUF_COUNT) + 6'(out_q) + 6'(inst_valid_q);
    req_valid = state_q == FETCH && !bus.iFLUSH && out_q < P_CNT_W'(P_MAX_OUTSTANDING) && credit < P_STOP_LEVEL;
    accept    = req_valid && !bus.iREQ_BUSY;
    rsp_ok    = bus.iRSP_VALID && out_q != '0;
    keep      = rsp_ok && disc_q == '0 && !bus.iFLUSH;
    out_d     = out_q + P_CNT_W'(accept) - P_CNT_W'(rsp_ok);
    disc_d    = bus.iFLUSH ? out_d : (rsp_ok && disc_q != '0) ? disc_q - 1'b1 : disc_q;
    pc_d      = bus.iFLUSH ? bus.iFLUSH_PC : accept ? pc_q + 32'd4 : pc_q;
    rsp_pc_d  = bus.iFLUSH ? bus.iFLUSH_PC : keep ? rsp_pc_q + 32'd4 : rsp_pc_q;
    inst_valid_d = keep;
    inst_d    = keep ? bus.iRSP_INST : inst_q;
    flags_d   = keep ? bus.iRSP_MMU_FLAGS : flags_q;
    opc_d     = keep ? rsp_pc_q : opc_q;
    proto_err_d = proto_err_q || (bus.iRSP_VALID && out_q == '0);
    state_d   = state_q;
    case (state_q)
      IDLE:    state_d = (!bus.iFLUSH && bus.iSTART) ? FETCH : IDLE;
      FETCH:   state_d = (bus.iFLUSH && disc_d != '0) ? DRAIN : FETCH;
      DRAIN:   state_d = disc_d == '0 ? FETCH : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      state_q      <= IDLE;
      pc_q         <= P_RESET_PC;
      rsp_pc_q     <= P_RESET_PC;
      out_q        <= '0;
      disc_q       <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      opc_q        <= '0;
      flags_q      <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      rsp_pc_q     <= rsp_pc_d;
      out_q        <= out_d;
      disc_q       <= disc_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      opc_q        <= opc_d;
      flags_q      <= flags_d;
      proto_err_q  <= proto_err_d;
    end
  end
  assign bus.oREQ_VALID  = req_valid;
  assign bus.oREQ_ADDR   = pc_q;
  assign bus.oINST_VALID = inst_valid_q;
  assign bus.oINST       = inst_q;
  assign bus.oPC         = opc_q;
  assign bus.oMMU_FLAGS  = flags_q;
  assign bus.oPROTO_ERR  = proto_err_q;
endmodule

// File: tb/tb_instruction_fetch_scheduler.sv
// tb_instruction_fetch_scheduler: directed checks of issue, credit throttle, flush/drain, wrap, protocol error and reset
module tb_instruction_fetch_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  instruction_fetch_scheduler_if bus ();
  instruction_fetch_scheduler dut (.iCLOCK(clk), .inRESET(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic rsp(input logic [31:0] inst, input logic [11:0] flags);
    bus.iRSP_VALID = 1'b1;
    bus.iRSP_INST = inst;
    bus.iRSP_MMU_FLAGS = flags;
    tick();
    bus.iRSP_VALID = 1'b0;
  endtask
  initial begin
    bus.iSTART = 0; bus.iFLUSH = 0; bus.iFLUSH_PC = 0; bus.iBUF_COUNT = 0;
    bus.iREQ_BUSY = 0; bus.iRSP_VALID = 0; bus.iRSP_INST = 0; bus.iRSP_MMU_FLAGS = 0;
    tick();
    tick();
    chk("rst_req_valid", 32'(bus.oREQ_VALID), 0);
    chk("rst_req_addr", bus.oREQ_ADDR, 0);
    chk("rst_inst_valid", 32'(bus.oINST_VALID), 0);
    chk("rst_pc", bus.oPC, 0);
    chk("rst_proto", 32'(bus.oPROTO_ERR), 0);
    rst_n = 1'b1;
    bus.iSTART = 1'b1;
    tick();
    bus.iSTART = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("issue_valid", 32'(bus.oREQ_VALID), 1);
      chk("issue_addr", bus.oREQ_ADDR, 32'(4 * i));
      tick();
    end
    #1;
    chk("max_outstanding", 32'(bus.oREQ_VALID), 0);
    bus.iREQ_BUSY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rsp(32'hA000_0000 + 32'(i), 12'(i + 1));
      chk("rsp_valid", 32'(bus.oINST_VALID), 1);
      chk("rsp_pc", bus.oPC, 32'(4 * i));
      chk("rsp_inst", bus.oINST, 32'hA000_0000 + 32'(i));
      chk("rsp_flags", 32'(bus.oMMU_FLAGS), 32'(i + 1));
    end
    tick();
    chk("rsp_idle", 32'(bus.oINST_VALID), 0);
    bus.iBUF_COUNT = 5'd24;
    bus.iREQ_BUSY = 1'b0;
    tick();
    chk("credit_one_more", 32'(bus.oREQ_VALID), 1);
    chk("credit_addr", bus.oREQ_ADDR, 32'd20);
    tick();
    chk("credit_block", 32'(bus.oREQ_VALID), 0);
    tick();
    chk("credit_block2", 32'(bus.oREQ_VALID), 0);
    bus.iBUF_COUNT = 5'd20;
    #1;
    chk("credit_resume", 32'(bus.oREQ_VALID), 1);
    chk("credit_resume_addr", bus.oREQ_ADDR, 32'd24);
    tick();
    bus.iREQ_BUSY = 1'b1;
    bus.iBUF_COUNT = 5'd0;
    bus.iFLUSH = 1'b1;
    bus.iFLUSH_PC = 32'h100;
    #1;
    chk("flush_no_req", 32'(bus.oREQ_VALID), 0);
    tick();
    bus.iFLUSH = 1'b0;
    bus.iREQ_BUSY = 1'b0;
    #1;
    chk("drain_no_req", 32'(bus.oREQ_VALID), 0);
    chk("drain_addr", bus.oREQ_ADDR, 32'h100);
    for (int i = 0; i < 3; i++) begin
      rsp(32'hDEAD_0000 + 32'(i), 12'hFFF);
      chk("drain_drop", 32'(bus.oINST_VALID), 0);
    end
    #1;
    chk("refetch_valid", 32'(bus.oREQ_VALID), 1);
    chk("refetch_addr", bus.oREQ_ADDR, 32'h100);
    tick();
    bus.iREQ_BUSY = 1'b1;
    rsp(32'hB000_0100, 12'h010);
    chk("refetch_rsp_valid", 32'(bus.oINST_VALID), 1);
    chk("refetch_rsp_pc", bus.oPC, 32'h100);
    bus.iREQ_BUSY = 1'b0;
    tick();
    tick();
    bus.iREQ_BUSY = 1'b1;
    bus.iFLUSH = 1'b1;
    bus.iFLUSH_PC = 32'h200;
    rsp(32'hDEAD_BEEF, 12'h0);
    bus.iFLUSH = 1'b0;
    chk("flush_rsp_drop", 32'(bus.oINST_VALID), 0);
    #1;
    chk("flush_rsp_drain", 32'(bus.oREQ_VALID), 0);
    rsp(32'hDEAD_BEEF, 12'h0);
    chk("flush_rsp_drop2", 32'(bus.oINST_VALID), 0);
    bus.iREQ_BUSY = 1'b0;
    #1;
    chk("flush_rsp_fetch", 32'(bus.oREQ_VALID), 1);
    chk("flush_rsp_addr", bus.oREQ_ADDR, 32'h200);
    bus.iREQ_BUSY = 1'b1;
    bus.iFLUSH = 1'b1;
    bus.iFLUSH_PC = 32'hFFFF_FFFC;
    tick();
    bus.iFLUSH = 1'b0;
    bus.iREQ_BUSY = 1'b0;
    #1;
    chk("wrap_addr_top", bus.oREQ_ADDR, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr_zero", bus.oREQ_ADDR, 32'h0);
    bus.iREQ_BUSY = 1'b1;
    rsp(32'hC000_0000, 12'h0);
    chk("wrap_rsp_pc", bus.oPC, 32'hFFFF_FFFC);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rsp(32'h1111_1111, 12'h1);
    chk("idle_proto_err", 32'(bus.oPROTO_ERR), 1);
    chk("idle_no_inst", 32'(bus.oINST_VALID), 0);
    tick();
    chk("proto_sticky", 32'(bus.oPROTO_ERR), 1);
    bus.iSTART = 1'b1;
    tick();
    bus.iSTART = 1'b0;
    bus.iREQ_BUSY = 1'b0;
    tick();
    tick();
    tick();
    bus.iREQ_BUSY = 1'b1;
    rsp(32'h2222_2222, 12'h22);
    chk("pre_rst_inst", bus.oINST, 32'h2222_2222);
    bus.iFLUSH = 1'b1;
    bus.iFLUSH_PC = 32'h300;
    tick();
    bus.iFLUSH = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("drain_rst_req_valid", 32'(bus.oREQ_VALID), 0);
    chk("drain_rst_addr", bus.oREQ_ADDR, 32'h0);
    chk("drain_rst_inst_valid", 32'(bus.oINST_VALID), 0);
    chk("drain_rst_inst", bus.oINST, 32'h0);
    chk("drain_rst_flags", 32'(bus.oMMU_FLAGS), 32'h0);
    chk("drain_rst_proto", 32'(bus.oPROTO_ERR), 0);
    rsp(32'h3333_3333, 12'h3);
    chk("post_rst_proto", 32'(bus.oPROTO_ERR), 1);
    chk("post_rst_no_inst", 32'(bus.oINST_VALID), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
